// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//   state_t      : controller state encoding (2 bits)
//   BCD_NINE     : largest legal units digit, also the reload value on borrow
//   is_bcd_digit : true when a 4-bit digit does not exceed the given limit
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    function automatic logic is_bcd_digit(input logic [3:0] digit,
                                          input logic [3:0] max_val);
        return (digit <= max_val);
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counting chain (purely combinational).
// Ports:
//   digit      in  4  current digit value
//   dec_in     in  1  decrement request (borrow from the less significant digit)
//   reload     in  4  value taken when decrementing from 0
//   next_digit out 4  digit value after this cycle's decrement (or unchanged)
//   borrow_out out 1  dec_in && digit==0, propagates to the next digit
module bcd_digit_down (
    input  logic [3:0] digit,
    input  logic       dec_in,
    input  logic [3:0] reload,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    logic w_is_zero;

    assign w_is_zero  = (digit == 4'd0);
    assign borrow_out = dec_in && w_is_zero;

    always_comb begin
        next_digit = digit;
        if (dec_in) begin
            next_digit = w_is_zero ? reload : (digit - 4'd1);
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD countdown timer, MM:SS (00:00..99:59).
// Loads a preset, counts down one second per tick_1hz, flags expiry with a
// one-cycle done pulse and an alarm level held until ack or a new load.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   tick_1hz                    one-cycle pulse per second
//   load, load_min_bcd/sec_bcd  preset capture request and {tens,units} values
//   start, stop, ack            control pulses
//   min_bcd, sec_bcd            current value {tens,units}
//   running                     high while counting
//   done                        one-cycle pulse on reaching 00:00 while counting
//   alarm                       high while expired
//   load_err                    one-cycle pulse when a preset is rejected
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int MIN_TENS_MAX = 9,
    parameter int SEC_TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic [7:0] load_min_bcd,
    input  logic [7:0] load_sec_bcd,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic       load_err
);

    localparam logic [3:0] MIN_TENS_RELOAD = 4'(MIN_TENS_MAX);
    localparam logic [3:0] SEC_TENS_RELOAD = 4'(SEC_TENS_MAX);

    state_t     r_state;
    logic [7:0] r_min;
    logic [7:0] r_sec;
    logic       r_running;
    logic       r_done;
    logic       r_alarm;
    logic       r_load_err;

    logic [7:0] w_min_nxt;
    logic [7:0] w_sec_nxt;
    logic       w_borrow_su;
    logic       w_borrow_st;
    logic       w_borrow_mu;
    logic       w_borrow_mt;
    logic       w_load_ok;
    logic       w_nonzero;
    logic       w_next_zero;

    // Borrow chain: seconds units -> seconds tens -> minutes units -> minutes tens.
    // The chain is only consumed on a RUN tick, so tick_1hz drives it directly.
    bcd_digit_down u_sec_units (
        .digit      (r_sec[3:0]),
        .dec_in     (tick_1hz),
        .reload     (BCD_NINE),
        .next_digit (w_sec_nxt[3:0]),
        .borrow_out (w_borrow_su)
    );

    bcd_digit_down u_sec_tens (
        .digit      (r_sec[7:4]),
        .dec_in     (w_borrow_su),
        .reload     (SEC_TENS_RELOAD),
        .next_digit (w_sec_nxt[7:4]),
        .borrow_out (w_borrow_st)
    );

    bcd_digit_down u_min_units (
        .digit      (r_min[3:0]),
        .dec_in     (w_borrow_st),
        .reload     (BCD_NINE),
        .next_digit (w_min_nxt[3:0]),
        .borrow_out (w_borrow_mu)
    );

    // A borrow out of the top digit cannot occur: counting stops at 00:00.
    bcd_digit_down u_min_tens (
        .digit      (r_min[7:4]),
        .dec_in     (w_borrow_mu),
        .reload     (MIN_TENS_RELOAD),
        .next_digit (w_min_nxt[7:4]),
        .borrow_out (w_borrow_mt)
    );

    assign w_load_ok = is_bcd_digit(load_min_bcd[7:4], MIN_TENS_RELOAD) &&
                       is_bcd_digit(load_min_bcd[3:0], BCD_NINE)        &&
                       is_bcd_digit(load_sec_bcd[7:4], SEC_TENS_RELOAD) &&
                       is_bcd_digit(load_sec_bcd[3:0], BCD_NINE);

    assign w_nonzero   = ({r_min, r_sec} != 16'h0000);
    assign w_next_zero = ({w_min_nxt, w_sec_nxt} == 16'h0000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_alarm    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            // Load is ignored while running, so it only claims the edge elsewhere;
            // a claimed edge drops any start/stop/ack presented with it.
            if (load && (r_state != ST_RUN)) begin
                if (w_load_ok) begin
                    r_min     <= load_min_bcd;
                    r_sec     <= load_sec_bcd;
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_alarm   <= 1'b0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (stop) begin
                            r_state   <= ST_PAUSED;
                            r_running <= 1'b0;
                        end else if (tick_1hz) begin
                            r_min <= w_min_nxt;
                            r_sec <= w_sec_nxt;
                            if (w_next_zero) begin
                                r_state   <= ST_EXPIRED;
                                r_running <= 1'b0;
                                r_alarm   <= 1'b1;
                                r_done    <= 1'b1;
                            end
                        end
                    end
                    ST_EXPIRED: begin
                        if (ack) begin
                            r_state <= ST_IDLE;
                            r_alarm <= 1'b0;
                        end
                    end
                    default: begin
                        // IDLE or PAUSED: stop outranks start even when it has no effect.
                        if (!stop && start && w_nonzero) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign min_bcd  = r_min;
    assign sec_bcd  = r_sec;
    assign running  = r_running;
    assign done     = r_done;
    assign alarm    = r_alarm;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_min_bcd = 8'h00;
    logic [7:0] load_sec_bcd = 8'h00;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;
    logic       alarm;
    logic       load_err;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: time held as a plain count of seconds.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;
    int m_secs  = 0;
    int m_state = M_IDLE;
    bit m_done  = 0;
    bit m_err   = 0;

    logic [7:0] r_lm;
    logic [7:0] r_ls;

    bcd_countdown_timer #(.MIN_TENS_MAX(9), .SEC_TENS_MAX(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1hz     (tick_1hz),
        .load         (load),
        .load_min_bcd (load_min_bcd),
        .load_sec_bcd (load_sec_bcd),
        .start        (start),
        .stop         (stop),
        .ack          (ack),
        .min_bcd      (min_bcd),
        .sec_bcd      (sec_bcd),
        .running      (running),
        .done         (done),
        .alarm        (alarm),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic bit legal(input logic [7:0] lm, input logic [7:0] ls);
        return (lm[7:4] <= 9) && (lm[3:0] <= 9) && (ls[7:4] <= 5) && (ls[3:0] <= 9);
    endfunction

    task automatic model_step(input bit rn, input bit ld, input logic [7:0] lm,
                              input logic [7:0] ls, input bit st, input bit sp,
                              input bit tk, input bit ak);
        m_done = 0;
        m_err  = 0;
        if (!rn) begin
            m_secs  = 0;
            m_state = M_IDLE;
        end else if (ld && m_state != M_RUN) begin
            if (legal(lm, ls)) begin
                m_secs  = int'(lm[7:4]) * 600 + int'(lm[3:0]) * 60 + int'(ls[7:4]) * 10 + int'(ls[3:0]);
                m_state = M_IDLE;
            end else begin
                m_err = 1;
            end
        end else if (m_state == M_RUN) begin
            if (sp) m_state = M_PAUSED;
            else if (tk) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_state = M_EXPIRED;
                    m_done  = 1;
                end
            end
        end else if (m_state == M_EXPIRED) begin
            if (ak) m_state = M_IDLE;
        end else begin
            if (!sp && st && m_secs != 0) m_state = M_RUN;
        end
    endtask

    // One clock: drive at negedge, model updates at posedge, outputs checked 1 time unit later.
    task automatic cyc(input bit rn, input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                       input bit st, input bit sp, input bit tk, input bit ak);
        @(negedge clk);
        rst_n = rn; load = ld; load_min_bcd = lm; load_sec_bcd = ls;
        start = st; stop = sp; tick_1hz = tk; ack = ak;
        @(posedge clk);
        model_step(rn, ld, lm, ls, st, sp, tk, ak);
        #1;
        check_val("value",    {min_bcd, sec_bcd}, to_bcd(m_secs));
        check_val("running",  running,  (m_state == M_RUN) ? 1 : 0);
        check_val("alarm",    alarm,    (m_state == M_EXPIRED) ? 1 : 0);
        check_val("done",     done,     m_done);
        check_val("load_err", load_err, m_err);
    endtask

    task automatic nop();               cyc(1, 0, 8'h00, 8'h00, 0, 0, 0, 0); endtask
    task automatic do_tick();           cyc(1, 0, 8'h00, 8'h00, 0, 0, 1, 0); endtask
    task automatic do_start();          cyc(1, 0, 8'h00, 8'h00, 1, 0, 0, 0); endtask
    task automatic do_stop();           cyc(1, 0, 8'h00, 8'h00, 0, 1, 0, 0); endtask
    task automatic do_ack();            cyc(1, 0, 8'h00, 8'h00, 0, 0, 0, 1); endtask
    task automatic do_reset();          cyc(0, 0, 8'h00, 8'h00, 0, 0, 0, 0); endtask
    task automatic do_load(input logic [7:0] lm, input logic [7:0] ls);
        cyc(1, 1, lm, ls, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        do_reset();
        check_val("rst_value", {min_bcd, sec_bcd}, 16'h0000);
        check_val("rst_flags", {running, done, alarm, load_err}, 4'b0000);

        // 01:00 -> one tick -> 00:59
        do_load(8'h01, 8'h00);
        do_start();
        do_tick();
        check_val("t1_value", {min_bcd, sec_bcd}, 16'h0059);
        check_val("t1_running", running, 1);
        check_val("t1_done", done, 0);

        // 00:02 -> expiry, done pulse, hold at 00:00, ack
        do_stop();
        do_load(8'h00, 8'h02);
        do_start();
        do_tick();
        do_tick();
        check_val("t2_done", done, 1);
        check_val("t2_alarm", alarm, 1);
        check_val("t2_zero", {min_bcd, sec_bcd}, 16'h0000);
        nop();
        check_val("t2_done_pulse", done, 0);
        for (int i = 0; i < 3; i++) do_tick();
        check_val("t2_hold", {min_bcd, sec_bcd}, 16'h0000);
        check_val("t2_alarm_hold", alarm, 1);
        do_ack();
        check_val("t2_ack_alarm", alarm, 0);
        check_val("t2_ack_run", running, 0);

        // 10:00 -> 09:59 borrow chain; illegal load rejected
        do_load(8'h10, 8'h00);
        do_start();
        do_tick();
        check_val("t3_borrow", {min_bcd, sec_bcd}, 16'h0959);
        do_stop();
        do_load(8'h00, 8'h7A);
        check_val("t3_err", load_err, 1);
        check_val("t3_keep", {min_bcd, sec_bcd}, 16'h0959);
        nop();
        check_val("t3_err_pulse", load_err, 0);

        // stop beats start; ticks while paused ignored
        do_load(8'h05, 8'h31);
        do_start();
        do_tick();
        check_val("t4_run", {min_bcd, sec_bcd}, 16'h0530);
        cyc(1, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        check_val("t4_paused", running, 0);
        for (int i = 0; i < 3; i++) do_tick();
        check_val("t4_frozen", {min_bcd, sec_bcd}, 16'h0530);
        do_start();
        do_tick();
        check_val("t4_resume", {min_bcd, sec_bcd}, 16'h0529);

        // start at 00:00 ignored; load+start: load wins
        do_reset();
        do_start();
        check_val("t5_no_start", running, 0);
        cyc(1, 1, 8'h03, 8'h00, 1, 0, 0, 0);
        check_val("t5_ld_start_run", running, 0);
        check_val("t5_ld_start_val", {min_bcd, sec_bcd}, 16'h0300);

        // reset mid-run
        do_load(8'h42, 8'h18);
        do_start();
        do_tick();
        check_val("t6_run", {min_bcd, sec_bcd}, 16'h4217);
        do_reset();
        check_val("t6_rst_value", {min_bcd, sec_bcd}, 16'h0000);
        check_val("t6_rst_flags", {running, done, alarm, load_err}, 4'b0000);

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            bit rn, ld, st, sp, tk, ak;
            rn = ($urandom % 300) != 0;
            ld = ($urandom % 25) == 0;
            r_lm = (($urandom % 2) == 0) ? 8'h00 : {4'($urandom % 10), 4'($urandom % 10)};
            r_ls = {4'($urandom % 6), 4'($urandom % 10)};
            case ($urandom % 10)
                0: r_ls[7:4] = 4'($urandom_range(6, 15));
                1: r_lm[3:0] = 4'($urandom_range(10, 15));
                2: r_ls[3:0] = 4'($urandom_range(10, 15));
                default: ;
            endcase
            st = ($urandom % 8) == 0;
            sp = ($urandom % 20) == 0;
            tk = ($urandom % 2) == 0;
            ak = ($urandom % 10) == 0;
            cyc(rn, ld, r_lm, r_ls, st, sp, tk, ak);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
